glitch_pulse_gen: RTL and testbench
===================================

Name: glitch_pulse_gen

Overview:
- Downstream consumer of the RX burst FIFO stage.
- Takes the 4-byte configuration burst (delay, width, repeat count) on a valid/byte stream and arms itself.
- On an external trigger rising edge, waits the programmed delay, then emits a programmable train of glitch pulses.
- One-shot: every firing needs a fresh 4-byte burst.

Parameters:
- DELAY_W, 16, delay counter width; bytes 0/1 form the delay, so DELAY_W is fixed at 16 and other values are unsupported.
- WIDTH_W, 8, pulse-width and gap counter width; fixed at 8 to match byte 2.

Ports:
- clk  in  1  system clock; sole clock domain.
- rst  in  1  asynchronous, active-high reset.
- in_dv  in  1  byte valid from upstream burst stage; one-cycle strobes, 4 on consecutive cycles per burst.
- in_byte  in  8  config byte; sampled when in_dv=1.
- trigger_in  in  1  external trigger; firing starts on its rising edge.
- glitch_out  out  1  registered glitch pulse output.
- armed  out  1  high while a valid config is held and the block waits for a trigger.
- busy  out  1  high in DELAY, PULSE and GAP.
- done  out  1  one-cycle strobe after the final pulse's last high cycle.
- cfg_err  out  1  one-cycle strobe on a bad or broken burst.

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, byte index 0, config registers 0. Outputs stay 0 while rst is held.
- Byte order: byte0 = delay[15:8], byte1 = delay[7:0], byte2 = width, byte3 = count.
- States:
  - IDLE
  - LOAD
  - ARMED
  - DELAY
  - PULSE
  - GAP
- IDLE/ARMED, in_dv=1: store byte0, idx=1, go to LOAD. armed drops the next cycle; a new burst always replaces the old config.
- LOAD, in_dv=1: store byte[idx] and increment idx.
  - On byte3: if width==0, pulse cfg_err and go to IDLE.
  - Otherwise go to ARMED; armed=1 from the next cycle.
- LOAD, in_dv=0 before byte3 (gap in burst): pulse cfg_err, idx=0, go to IDLE.
- count==0 is treated as 1.
- Trigger edge detect: rise = trig_s & ~trig_q, where trig_s is trigger_in (or its synchronised copy, see Optional Feature). Edges outside ARMED are ignored.
- ARMED + rise at edge T:
  - Load the delay counter with D and go to DELAY.
  - The first high cycle of glitch_out is the cycle after edge T+D+1.
  - D=0 gives a pulse beginning one cycle after the detect cycle.
- PULSE: glitch_out=1 for exactly W cycles.
  - Then, if remaining repeats > 0, go to GAP.
  - Otherwise pulse done for 1 cycle, coincident with glitch_out falling, and go to IDLE (config retained, armed=0).
- GAP: glitch_out=0 for exactly W cycles, then back to PULSE.
- in_dv during DELAY/PULSE/GAP is ignored; the bytes are dropped and firing is not aborted.
- Trigger edges during firing are ignored.
- Simultaneous in_dv and rise in ARMED: in_dv wins; the block goes to LOAD and the trigger is dropped.
- Counters are unsigned. The delay counter is 16-bit, width/gap are 8-bit, and the repeat counter is 8-bit; none wrap during operation.
- Max train length: 255 pulses.

Optional Feature:
- Macro GLITCH_TRIG_SYNC_EN.
- Defined: trigger_in passes through a 2-flop synchroniser before edge detect. Trigger-to-glitch latency grows by 2 cycles, so the first high cycle comes after edge T+D+3, where T is the first edge at which trigger_in is sampled high.
- Undefined: trigger_in is assumed synchronous to clk and feeds the edge detector directly, with latency as in Behaviour.

Decomposition:
- Package glitch_pkg holds:
  - the state enum typedef
  - CFG_BYTES=4
  - byte index localparams (IDX_DLY_HI=0, IDX_DLY_LO=1, IDX_WIDTH=2, IDX_COUNT=3)
- One natural sub-module, glitch_trig_sync: optional synchroniser plus rising-edge detector, outputting a one-cycle rise.

Test Plan:
- Burst 00,03,02,02 on 4 consecutive cycles → armed=1; trigger rise at T → glitch_out high for 2 cycles starting after edge T+4, low for 2 cycles, high for 2 cycles; done strobes with the second fall; armed=0.
- Burst 00,00,01,00 (D=0, W=1, count 0 treated as 1) → a single 1-cycle pulse starting after edge T+1, then done.
- Burst 00,05,00,01 (W=0) → cfg_err strobe, armed stays 0, and a later trigger produces no pulse.
- Send 2 bytes, then in_dv=0 for one cycle → cfg_err; then a full valid burst → armed=1 with no leftover bytes.
- Mid-PULSE: assert rst → glitch_out, busy and armed read 0 the same cycle; after release, a trigger alone produces no output.
- GLITCH_TRIG_SYNC_EN defined, burst 00,03,02,01 → the first glitch_out high cycle is 2 cycles later than in the undefined build.

Source files
------------

// File: rtl/glitch_pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : glitch_pkg
//  Purpose  : Shared definitions for the glitch pulse generator slice:
//             firing state encoding, configuration burst length and the
//             byte positions inside a configuration burst.
//  Contents : glitch_state_e   - state enumeration (3-bit encoding)
//             ST_*             - legacy-compatible state constants
//             CFG_BYTES        - bytes per configuration burst
//             IDX_*            - byte index of each configuration field
//             reps_after_first - repeats remaining once the first pulse
//                                of a train has been issued
//  Revision : 1.0 - initial release
// ============================================================================
package glitch_pkg;

    // Firing state machine encoding.
    typedef enum logic [2:0] {
        GS_IDLE  = 3'd0,
        GS_LOAD  = 3'd1,
        GS_ARMED = 3'd2,
        GS_DELAY = 3'd3,
        GS_PULSE = 3'd4,
        GS_GAP   = 3'd5
    } glitch_state_e;

    // Plain vector copies of the encoding, so state registers can stay
    // ordinary logic vectors in the datapath.
    localparam logic [2:0] ST_IDLE  = GS_IDLE;
    localparam logic [2:0] ST_LOAD  = GS_LOAD;
    localparam logic [2:0] ST_ARMED = GS_ARMED;
    localparam logic [2:0] ST_DELAY = GS_DELAY;
    localparam logic [2:0] ST_PULSE = GS_PULSE;
    localparam logic [2:0] ST_GAP   = GS_GAP;

    // Configuration burst layout.
    localparam int         CFG_BYTES  = 4;
    localparam logic [1:0] IDX_DLY_HI = 2'd0;
    localparam logic [1:0] IDX_DLY_LO = 2'd1;
    localparam logic [1:0] IDX_WIDTH  = 2'd2;
    localparam logic [1:0] IDX_COUNT  = 2'd3;

    // A programmed count of 0 behaves like 1, so the number of repeats
    // after the first pulse is count-1 saturated at zero.
    function automatic logic [7:0] reps_after_first(input logic [7:0] count);
        if (count == 8'd0) begin
            return 8'd0;
        end
        return count - 8'd1;
    endfunction

endpackage : glitch_pkg
`default_nettype wire

// File: rtl/glitch_pulse_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : glitch_cfg_if
//  Purpose  : Configuration byte stream from the RX burst FIFO stage into
//             the glitch pulse generator.
//  Signals  : in_dv   - one-cycle byte strobe, four back-to-back per burst
//             in_byte - configuration byte, valid while in_dv is high
//  Modports : master  - upstream burst stage (drives the stream)
//             slave   - glitch pulse generator (consumes the stream)
//  Revision : 1.0 - initial release
// ============================================================================
interface glitch_cfg_if;

    logic       in_dv;
    logic [7:0] in_byte;

    modport master (
        output in_dv,
        output in_byte
    );

    modport slave (
        input  in_dv,
        input  in_byte
    );

endinterface : glitch_cfg_if
`default_nettype wire

// File: rtl/glitch_pulse_gen_trig_sync.sv
`default_nettype none
// ============================================================================
//  Module   : glitch_trig_sync
//  Purpose  : Trigger conditioning for the glitch pulse generator. Produces
//             a one-cycle strobe on each rising edge of the trigger.
//             Build option GLITCH_TRIG_SYNC_EN inserts a 2-flop synchroniser
//             ahead of the edge detector for an asynchronous trigger source
//             (adds 2 cycles of trigger-to-strobe latency). Without it the
//             trigger is taken to be synchronous to clk.
//  Ports    : clk     - system clock
//             rst     - asynchronous active-high reset
//             trig_in - raw external trigger
//             rise    - one-cycle rising-edge strobe (combinational from
//                       the conditioned trigger and its registered copy)
//  Revision : 1.0 - initial release
// ============================================================================
module glitch_trig_sync (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic trig_in,
    output logic      rise
);

    logic w_trig_s;
    logic r_trig_q;

`ifdef GLITCH_TRIG_SYNC_EN
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= trig_in;
            r_sync <= r_meta;
        end
    end

    assign w_trig_s = r_sync;
`else
    assign w_trig_s = trig_in;
`endif

    // Previous value of the conditioned trigger; a level already high
    // when the block becomes armed does not count as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_q <= 1'b0;
        end else begin
            r_trig_q <= w_trig_s;
        end
    end

    assign rise = w_trig_s & ~r_trig_q;

endmodule : glitch_trig_sync
`default_nettype wire

// File: rtl/glitch_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : glitch_pulse_gen
//  Purpose  : One-shot glitch pulse generator. A 4-byte configuration burst
//             (delay hi, delay lo, width, count) arms the block; the next
//             trigger rising edge starts a delay of D cycles followed by a
//             train of count pulses, each W cycles high with W-cycle gaps.
//             Every firing needs a fresh burst.
//             Build option GLITCH_TRIG_SYNC_EN (in glitch_trig_sync) adds a
//             2-flop trigger synchroniser and 2 cycles of latency.
//  Ports    : clk        - system clock, single domain
//             rst        - asynchronous active-high reset
//             cfg        - configuration byte stream (glitch_cfg_if.slave)
//             trigger_in - external trigger, fires on rising edge
//             glitch_out - registered glitch pulse output
//             armed      - valid config held, waiting for trigger
//             busy       - delay / pulse / gap in progress
//             done       - one-cycle strobe as the last pulse falls
//             cfg_err    - one-cycle strobe on a bad or broken burst
//  Revision : 1.0 - initial release
// ============================================================================
module glitch_pulse_gen
    import glitch_pkg::*;
#(
    parameter int DELAY_W = 16,
    parameter int WIDTH_W = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    glitch_cfg_if.slave cfg,
    input  wire logic   trigger_in,
    output logic        glitch_out,
    output logic        armed,
    output logic        busy,
    output logic        done,
    output logic        cfg_err
);

    // ------------------------------------------------------------------
    // State and configuration
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [1:0]         r_idx;

    logic [7:0]         r_cfg_dly_hi;
    logic [7:0]         r_cfg_dly_lo;
    logic [WIDTH_W-1:0] r_cfg_width;
    logic [WIDTH_W-1:0] r_cfg_count;

    logic [DELAY_W-1:0] r_dly_cnt;
    logic [WIDTH_W-1:0] r_wid_cnt;   // shared by PULSE high and GAP low phases
    logic [WIDTH_W-1:0] r_rep_cnt;   // pulses still to follow the current one

    logic               r_glitch;
    logic               r_done;
    logic               r_cfg_err;

    logic               w_rise;
    logic [WIDTH_W-1:0] w_width_m1;

    // ------------------------------------------------------------------
    // Trigger conditioning
    // ------------------------------------------------------------------
    glitch_trig_sync u_trig_sync (
        .clk     (clk),
        .rst     (rst),
        .trig_in (trigger_in),
        .rise    (w_rise)
    );

    // Phase counters count down to zero, so they load W-1 to give W cycles.
    // W is never 0 here: a zero width is rejected at load time.
    assign w_width_m1 = r_cfg_width - WIDTH_W'(1);

    // ------------------------------------------------------------------
    // Main state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= IDX_DLY_HI;
            r_cfg_dly_hi <= '0;
            r_cfg_dly_lo <= '0;
            r_cfg_width  <= '0;
            r_cfg_count  <= '0;
            r_dly_cnt    <= '0;
            r_wid_cnt    <= '0;
            r_rep_cnt    <= '0;
            r_glitch     <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            // Strobes default low and are raised for a single cycle.
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;

            case (r_state)
                ST_IDLE,
                ST_ARMED: begin
                    // A new burst takes priority over a trigger edge in the
                    // same cycle and always replaces the held config.
                    if (cfg.in_dv) begin
                        r_cfg_dly_hi <= cfg.in_byte;
                        r_idx        <= IDX_DLY_LO;
                        r_state      <= ST_LOAD;
                    end else if ((r_state == ST_ARMED) && w_rise) begin
                        r_dly_cnt <= DELAY_W'({r_cfg_dly_hi, r_cfg_dly_lo});
                        r_rep_cnt <= reps_after_first(r_cfg_count);
                        r_state   <= ST_DELAY;
                    end
                end

                ST_LOAD: begin
                    if (cfg.in_dv) begin
                        case (r_idx)
                            IDX_DLY_LO: r_cfg_dly_lo <= cfg.in_byte;
                            IDX_WIDTH:  r_cfg_width  <= cfg.in_byte;
                            IDX_COUNT:  r_cfg_count  <= cfg.in_byte;
                            default:    r_cfg_dly_hi <= cfg.in_byte;
                        endcase

                        if (r_idx == IDX_COUNT) begin
                            // Width was captured on the previous byte, so
                            // it can be validated as the burst completes.
                            r_idx <= IDX_DLY_HI;
                            if (r_cfg_width == '0) begin
                                r_cfg_err <= 1'b1;
                                r_state   <= ST_IDLE;
                            end else begin
                                r_state   <= ST_ARMED;
                            end
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end else begin
                        // Burst broken by a missing strobe: discard it.
                        r_cfg_err <= 1'b1;
                        r_idx     <= IDX_DLY_HI;
                        r_state   <= ST_IDLE;
                    end
                end

                ST_DELAY: begin
                    if (r_dly_cnt == '0) begin
                        r_glitch  <= 1'b1;
                        r_wid_cnt <= w_width_m1;
                        r_state   <= ST_PULSE;
                    end else begin
                        r_dly_cnt <= r_dly_cnt - DELAY_W'(1);
                    end
                end

                ST_PULSE: begin
                    if (r_wid_cnt == '0) begin
                        r_glitch <= 1'b0;
                        if (r_rep_cnt != '0) begin
                            r_rep_cnt <= r_rep_cnt - WIDTH_W'(1);
                            r_wid_cnt <= w_width_m1;
                            r_state   <= ST_GAP;
                        end else begin
                            // done coincides with the final falling edge;
                            // the config stays but the block is no longer
                            // armed (one-shot).
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_wid_cnt <= r_wid_cnt - WIDTH_W'(1);
                    end
                end

                ST_GAP: begin
                    if (r_wid_cnt == '0) begin
                        r_glitch  <= 1'b1;
                        r_wid_cnt <= w_width_m1;
                        r_state   <= ST_PULSE;
                    end else begin
                        r_wid_cnt <= r_wid_cnt - WIDTH_W'(1);
                    end
                end

                default: begin
                    r_glitch <= 1'b0;
                    r_idx    <= IDX_DLY_HI;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign glitch_out = r_glitch;
    assign done       = r_done;
    assign cfg_err    = r_cfg_err;
    assign armed      = (r_state == ST_ARMED);
    assign busy       = (r_state == ST_DELAY) ||
                        (r_state == ST_PULSE) ||
                        (r_state == ST_GAP);

endmodule : glitch_pulse_gen
`default_nettype wire

// File: tb/tb_glitch_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_glitch_pulse_gen
//  Purpose  : Self-checking bench for glitch_pulse_gen. Stimulus pushes the
//             expected output events (pulse rise/fall, done, cfg_err) and
//             expected output levels, tagged with the clock cycle they must
//             appear in; a monitor samples the outputs on each falling clock
//             edge and compares against the queues.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_glitch_pulse_gen;

`ifdef GLITCH_TRIG_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    localparam int EV_RISE = 0;
    localparam int EV_FALL = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    typedef struct {
        int         cyc;
        logic [2:0] v;      // {armed, busy, glitch_out}
    } lv_t;

    logic clk = 1'b0;
    logic rst;
    logic trigger_in;
    logic glitch_out;
    logic armed;
    logic busy;
    logic done;
    logic cfg_err;

    glitch_cfg_if cfg_if ();

    glitch_pulse_gen dut (
        .clk        (clk),
        .rst        (rst),
        .cfg        (cfg_if),
        .trigger_in (trigger_in),
        .glitch_out (glitch_out),
        .armed      (armed),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t exp_q[$];
    lv_t lvl_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  flush    = 1'b0;

    function automatic string kname(input int k);
        case (k)
            EV_RISE: return "rise";
            EV_FALL: return "fall";
            EV_DONE: return "done";
            default: return "cfg_err";
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin : monitor
        logic       prev;
        logic [3:0] obs;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            obs[EV_RISE] = glitch_out & ~prev;
            obs[EV_FALL] = ~glitch_out & prev;
            obs[EV_DONE] = done;
            obs[EV_ERR]  = cfg_err;
            prev         = glitch_out;

            for (int k = 0; k < 4; k++) begin
                if (obs[k]) begin
                    n_checks++;
                    if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].kind == k) begin
                        n_pass++;
                        void'(exp_q.pop_front());
                    end else begin
                        $display("FAIL event_%s: seen at cycle %0d, required none here (next expected %0d at cycle %0d)",
                                 kname(k), cyc, exp_q.size(), (exp_q.size() > 0) ? exp_q[0].cyc : -1);
                    end
                end
            end

            while (exp_q.size() > 0 && (exp_q[0].cyc <= cyc || flush)) begin
                n_checks++;
                $display("FAIL event_%s: not seen, required at cycle %0d (now %0d)",
                         kname(exp_q[0].kind), exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end

            while (lvl_q.size() > 0 && (lvl_q[0].cyc <= cyc || flush)) begin
                n_checks++;
                if (lvl_q[0].cyc == cyc && {armed, busy, glitch_out} === lvl_q[0].v) begin
                    n_pass++;
                end else begin
                    $display("FAIL level @%0d: armed/busy/glitch = %b at cycle %0d, required %b",
                             lvl_q[0].cyc, {armed, busy, glitch_out}, cyc, lvl_q[0].v);
                end
                void'(lvl_q.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all drive 1 time unit after a falling edge)
    // ------------------------------------------------------------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Sends a 4-byte burst on consecutive cycles. A zero width byte must
    // raise cfg_err as the last byte lands; otherwise armed must be high.
    // trig drives a trigger rising edge together with the first byte.
    task automatic send_burst(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input bit trig);
        logic [7:0] bytes [4];
        bytes[0] = b0;
        bytes[1] = b1;
        bytes[2] = b2;
        bytes[3] = b3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            cfg_if.in_dv   = 1'b1;
            cfg_if.in_byte = bytes[i];
            if (i == 0 && trig) trigger_in = 1'b1;
            if (i == 3) begin
                if (b2 == 8'd0) exp_q.push_back('{cyc + 1, EV_ERR});
                else            lvl_q.push_back('{cyc + 2, 3'b100});
            end
        end
        @(negedge clk);
        #1;
        cfg_if.in_dv   = 1'b0;
        cfg_if.in_byte = 8'h00;
        trigger_in     = 1'b0;
    endtask

    // One-cycle trigger pulse. first_off: cycles from the trigger sample
    // edge to the first pulse (hand-computed D+1, synchroniser added here);
    // w: pulse width; n: pulses in the train.
    task automatic fire(input int first_off, input int w, input int n);
        int t, r, last;
        @(negedge clk);
        #1;
        trigger_in = 1'b1;
        t = cyc + 1;
        r = t + first_off + SYNC;
        last = r;
        lvl_q.push_back('{r, 3'b011});
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{r, EV_RISE});
            exp_q.push_back('{r + w, EV_FALL});
            if (i == n - 1) exp_q.push_back('{r + w, EV_DONE});
            last = r + w;
            r    = r + 2 * w;
        end
        @(negedge clk);
        #1;
        trigger_in = 1'b0;
        while (cyc < last) @(negedge clk);
        #1;
        lvl_q.push_back('{cyc + 1, 3'b000});
        wait_cycles(3);
    endtask

    // Trigger pulse that must produce nothing.
    task automatic fire_none();
        @(negedge clk);
        #1;
        trigger_in = 1'b1;
        @(negedge clk);
        #1;
        trigger_in = 1'b0;
        lvl_q.push_back('{cyc + 5, 3'b000});
        wait_cycles(20);
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin : stimulus
        int t, r;
        rst            = 1'b1;
        trigger_in     = 1'b0;
        cfg_if.in_dv   = 1'b0;
        cfg_if.in_byte = 8'h00;

        // Reset state, during and just after reset.
        lvl_q.push_back('{1, 3'b000});
        lvl_q.push_back('{4, 3'b000});
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2);

        // D=3 W=2 count=2: pulses at T+4..T+5 and T+8..T+9, done at T+10.
        send_burst(8'h00, 8'h03, 8'h02, 8'h02, 1'b0);
        fire(4, 2, 2);

        // D=0 W=1 count=0 (acts as 1): single pulse at T+1.
        send_burst(8'h00, 8'h00, 8'h01, 8'h00, 1'b0);
        fire(1, 1, 1);

        // W=0: cfg_err, not armed, trigger ignored.
        send_burst(8'h00, 8'h05, 8'h00, 8'h01, 1'b0);
        fire_none();

        // Broken burst: two bytes then a gap.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            cfg_if.in_dv   = 1'b1;
            cfg_if.in_byte = 8'h07;
        end
        @(negedge clk);
        #1;
        cfg_if.in_dv   = 1'b0;
        cfg_if.in_byte = 8'h00;
        exp_q.push_back('{cyc + 1, EV_ERR});
        lvl_q.push_back('{cyc + 2, 3'b000});
        wait_cycles(2);
        // A full burst afterwards must load cleanly: D=2 W=3 count=1.
        send_burst(8'h00, 8'h02, 8'h03, 8'h01, 1'b0);
        fire(3, 3, 1);

        // D=3 W=2 count=1: first pulse at T+4 (T+6 with synchroniser).
        send_burst(8'h00, 8'h03, 8'h02, 8'h01, 1'b0);
        fire(4, 2, 1);

        // in_dv and trigger edge together while armed: burst wins, trigger
        // dropped. New config D=1 W=1 count=1 then fires normally.
        send_burst(8'h00, 8'h00, 8'h01, 8'h01, 1'b0);
        send_burst(8'h00, 8'h01, 8'h01, 8'h01, 1'b1);
        wait_cycles(2);
        fire(2, 1, 1);

        // Reset in the middle of a pulse: D=1 W=4 count=3.
        send_burst(8'h00, 8'h01, 8'h04, 8'h03, 1'b0);
        @(negedge clk);
        #1;
        trigger_in = 1'b1;
        t = cyc + 1;
        r = t + 2 + SYNC;
        exp_q.push_back('{r, EV_RISE});
        lvl_q.push_back('{r, 3'b011});
        @(negedge clk);
        #1;
        trigger_in = 1'b0;
        while (cyc < r + 1) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.push_back('{cyc, EV_FALL});
        lvl_q.push_back('{cyc, 3'b000});
        wait_cycles(2);
        rst = 1'b0;
        fire_none();

        // Anything still queued is a missing event.
        wait_cycles(3);
        flush = 1'b1;
        wait_cycles(1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_glitch_pulse_gen
`default_nettype wire
